// File: rtl/x_multdiv.sv
// Iterative signed 32x32 multiply / 32/32 divide for the execute stage.
// Holds the F/D and D/X latches via stall while a 32-cycle shift-add or restoring divide runs.
module x_multdiv (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        is_div,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  rd_in,
    output logic        stall,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result,
    output logic        exception,
    output logic [4:0]  rd_out
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] a_q;       // |multiplicand|, or |dividend| shifting into quotient
    logic [31:0] b_q;       // |multiplier| (shifts right) or |divisor|
    logic        sign_q;
    logic [4:0]  rd_q;
    logic [63:0] acc_q;
    logic [31:0] rem_q;
    logic        busy_q;
    logic        valid_q;
    logic [31:0] result_q;
    logic        exc_q;
    logic [4:0]  rd_out_q;

    function automatic logic [31:0] mag32(input logic signed [31:0] v);
        logic signed [31:0] n;
        n = -v;
        return v[31] ? n : v;
    endfunction

    function automatic logic [63:0] apply_sign64(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    function automatic logic [31:0] apply_sign32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    // Product fits in 32 signed bits only when bits 63..31 are a pure sign extension.
    function automatic logic mul_overflow(input logic [63:0] p);
        return !((p[63:31] == 33'd0) || (p[63:31] == {33{1'b1}}));
    endfunction

    logic        div_zero;
    logic        div_ovf;
    logic        div_special;
    logic [32:0] mul_sum;
    logic [63:0] acc_d;
    logic [63:0] prod_d;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        qbit;
    logic [31:0] rem_d;
    logic [31:0] quo_d;

    always_comb begin
        div_zero    = (operand_b == 32'd0);
        div_ovf     = (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
        div_special = is_div && (div_zero || div_ovf);

        stall = ((state_q == S_IDLE) && start && !div_special)
              || (state_q == S_MUL) || (state_q == S_DIV);

        // Shift-add: add multiplicand into the upper half when the current multiplier bit is set.
        mul_sum = {1'b0, acc_q[63:32]} + {1'b0, (b_q[0] ? a_q : 32'd0)};
        acc_d   = {mul_sum, acc_q[31:1]};
        prod_d  = apply_sign64(acc_d, sign_q);

        // Restoring division: keep the trial subtraction only when it does not go negative.
        div_shift = {rem_q, a_q[31]};
        div_diff  = div_shift - {1'b0, b_q};
        qbit      = ~div_diff[32];
        rem_d     = qbit ? div_diff[31:0] : div_shift[31:0];
        quo_d     = {a_q[30:0], qbit};
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
            rd_out_q <= 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    valid_q <= 1'b0;
                    if (start) begin
                        if (div_special) begin
                            state_q  <= S_DONE;
                            valid_q  <= 1'b1;
                            result_q <= div_zero ? 32'd0 : 32'h8000_0000;
                            exc_q    <= 1'b1;
                            rd_out_q <= rd_in;
                        end else begin
                            a_q     <= mag32(operand_a);
                            b_q     <= mag32(operand_b);
                            sign_q  <= operand_a[31] ^ operand_b[31];
                            rd_q    <= rd_in;
                            acc_q   <= 64'd0;
                            rem_q   <= 32'd0;
                            cnt_q   <= 6'd0;
                            busy_q  <= 1'b1;
                            state_q <= is_div ? S_DIV : S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= acc_d;
                    b_q   <= {1'b0, b_q[31:1]};
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        valid_q  <= 1'b1;
                        result_q <= prod_d[31:0];
                        exc_q    <= mul_overflow(prod_d);
                        rd_out_q <= rd_q;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    a_q   <= quo_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        valid_q  <= 1'b1;
                        result_q <= apply_sign32(quo_d, sign_q);
                        exc_q    <= 1'b0;
                        rd_out_q <= rd_q;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign result       = result_q;
    assign exception    = exc_q;
    assign rd_out       = rd_out_q;

endmodule

// File: tb/tb_x_multdiv.sv
// Directed bench for x_multdiv: latency, stall window, signed results, exceptions, abort.
module tb_x_multdiv;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        is_div;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd_in;
    logic        stall;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;
    logic        exception;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    x_multdiv dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .is_div       (is_div),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .rd_in        (rd_in),
        .stall        (stall),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .exception    (exception),
        .rd_out       (rd_out)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Start one operation at cycle T (a negedge), then follow it until result_valid.
    task automatic run_op(input string name, input logic div, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input logic exp_exc, input int exp_lat);
        int   cyc;
        int   stall_hi;
        logic seen;
        @(negedge clock);
        check({name, ":rv_idle"}, {31'd0, result_valid}, 32'd0);
        start     = 1'b1;
        is_div    = div;
        operand_a = a;
        operand_b = b;
        rd_in     = rd;
        #1;
        check({name, ":stall_T"}, {31'd0, stall}, (exp_lat == 1) ? 32'd0 : 32'd1);
        cyc = 0;
        stall_hi = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clock);
            start     = 1'b0;
            operand_a = 32'hDEAD_BEEF;
            operand_b = 32'h1234_5678;
            rd_in     = 5'd31;
            #1;
            cyc++;
            if (result_valid) seen = 1'b1;
            else begin
                if (stall) stall_hi++;
                if (cyc == 16) check({name, ":busy_mid"}, {31'd0, busy}, 32'd1);
            end
        end
        check({name, ":latency"}, cyc, exp_lat);
        check({name, ":stall_cycles"}, stall_hi, exp_lat - 1);
        check({name, ":stall_done"}, {31'd0, stall}, 32'd0);
        check({name, ":busy_done"}, {31'd0, busy}, 32'd0);
        check({name, ":result"}, result, exp_res);
        check({name, ":exception"}, {31'd0, exception}, {31'd0, exp_exc});
        check({name, ":rd_out"}, {27'd0, rd_out}, {27'd0, rd});
    endtask

    initial begin
        int pulses;
        reset_n   = 1'b0;
        start     = 1'b0;
        is_div    = 1'b0;
        operand_a = 32'd0;
        operand_b = 32'd0;
        rd_in     = 5'd0;
        repeat (3) @(negedge clock);
        check("rst:busy", {31'd0, busy}, 32'd0);
        check("rst:rv", {31'd0, result_valid}, 32'd0);
        check("rst:result", result, 32'd0);
        check("rst:exc", {31'd0, exception}, 32'd0);
        check("rst:rd_out", {27'd0, rd_out}, 32'd0);
        check("rst:stall", {31'd0, stall}, 32'd0);
        reset_n = 1'b1;

        run_op("mul_7x6",     1'b0, 32'd7,          32'd6,          5'd5,  32'd42,         1'b0, 33);
        run_op("mul_m5x3",    1'b0, 32'hFFFF_FFFB,  32'd3,          5'd6,  32'hFFFF_FFF1,  1'b0, 33);
        run_op("mul_ovf",     1'b0, 32'h0001_0000,  32'h0001_0000,  5'd7,  32'd0,          1'b1, 33);
        run_op("mul_min_m1",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h8000_0000,  1'b1, 33);
        run_op("mul_negmin",  1'b0, 32'hFFFF_8000,  32'h0001_0000,  5'd10, 32'h8000_0000,  1'b0, 33);
        run_op("mul_m1xm1",   1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd11, 32'd1,          1'b0, 33);
        run_op("div_100_m7",  1'b1, 32'd100,        32'hFFFF_FFF9,  5'd8,  32'hFFFF_FFF2,  1'b0, 33);
        run_op("div_m100_7",  1'b1, 32'hFFFF_FF9C,  32'd7,          5'd12, 32'hFFFF_FFF2,  1'b0, 33);
        run_op("div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          5'd13, 32'hFFFF_FFFD,  1'b0, 33);
        run_op("div_min_1",   1'b1, 32'h8000_0000,  32'd1,          5'd14, 32'h8000_0000,  1'b0, 33);
        run_op("div_by0",     1'b1, 32'd5,          32'd0,          5'd15, 32'd0,          1'b1, 1);
        run_op("div_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'h8000_0000,  1'b1, 1);
        run_op("b2b_3x4",     1'b0, 32'd3,          32'd4,          5'd17, 32'd12,         1'b0, 33);
        run_op("b2b_5x5",     1'b0, 32'd5,          32'd5,          5'd18, 32'd25,         1'b0, 33);

        @(negedge clock);
        #1;
        check("hold:result", result, 32'd25);
        check("hold:rd_out", {27'd0, rd_out}, 32'd18);
        check("hold:rv_low", {31'd0, result_valid}, 32'd0);

        // Abort a multiply with reset at T+10.
        @(negedge clock);
        start     = 1'b1;
        is_div    = 1'b0;
        operand_a = 32'd7;
        operand_b = 32'd6;
        rd_in     = 5'd3;
        repeat (10) begin
            @(negedge clock);
            start = 1'b0;
        end
        reset_n = 1'b0;
        @(negedge clock);
        #1;
        check("abort:stall", {31'd0, stall}, 32'd0);
        check("abort:busy", {31'd0, busy}, 32'd0);
        check("abort:rv", {31'd0, result_valid}, 32'd0);
        check("abort:result", result, 32'd0);
        reset_n = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(negedge clock);
            #1;
            if (result_valid) pulses++;
        end
        check("abort:no_pulse", pulses, 32'd0);
        check("abort:idle_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/x_multdiv.md
# x_multdiv

Iterative signed multiply/divide unit for the execute stage. It consumes the decoded mul/div flags and register operands leaving the D/X pipeline latch. It holds the pipeline, by driving the D/X and F/D latch enables low, for the duration of a multi-cycle operation. It then presents a 32-bit result plus exception flag for the X/M latch to capture.

## Interface
Parameters:
- none; datapath fixed at 32 bits, iteration count fixed at 32.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset; sampled on rising edge of clock
- start  in  1  X-stage instruction is mul or div and not a NOP (isMul_out|isDiv_out)&~NOP_dx
- is_div  in  1  1 = divide, 0 = multiply; valid when start=1
- operand_a  in  32  rs value (multiplicand / dividend), two's complement
- operand_b  in  32  rt value (multiplier / divisor), two's complement
- rd_in  in  5  destination register of the X-stage instruction
- stall  out  1  high = hold F/D and D/X latches (drive their ena low); combinational
- busy  out  1  high while in MUL or DIV state; registered
- result_valid  out  1  one-cycle pulse; result/exception/rd_out valid
- result  out  32  low 32 bits of product, or quotient
- exception  out  1  mul overflow, div by zero, or div overflow
- rd_out  out  5  latched destination register, valid with result_valid

## Operation
- States: IDLE, MUL, DIV, DONE. Reset (reset_n=0 at a clock edge) forces IDLE, 6-bit counter=0, and busy, result_valid, result, exception, rd_out=0. This holds from any state, including mid-operation; no result is produced for an aborted operation.
- IDLE, start=1, is_div=0: latch |a|, |b|, sign=a[31]^b[31], rd_in; clear 64-bit accumulator; go MUL.
- IDLE, start=1, is_div=1, operand_b=0: go DONE with result=0, exception=1.
- IDLE, start=1, is_div=1, a=0x80000000, b=0xFFFFFFFF: go DONE with result=0x80000000, exception=1.
- IDLE, start=1, other divide: latch magnitudes, sign, rd_in; clear remainder; go DIV.
- MUL: unsigned shift-add, one multiplier bit per cycle, 32 cycles (counter 0..31). On counter=31 go DONE.
- DONE after MUL: apply two's-complement negate if sign=1 to the 64-bit product.
  - result = product[31:0].
  - exception = 1 iff product[63:31] is not all-zeros and not all-ones.
- DIV: restoring division, one quotient bit per cycle, 32 cycles. On counter=31 go DONE.
  - Quotient is negated if sign=1, giving truncation toward zero. Remainder is discarded.
  - exception=0.
- DONE: result_valid=1 for exactly one cycle; start is ignored; next state IDLE unconditionally.
- stall = (state==IDLE & start & not a zero/overflow divide) | state==MUL | state==DIV.
  - stall is low in DONE, so the instruction advances to M while result is valid.
- result, exception, rd_out hold their values after DONE until the next DONE or reset.

## Timing
- Normal mul/div: start seen in IDLE at cycle T. Stall high in cycles T..T+32. MUL/DIV occupies T+1..T+32. DONE and result_valid occur at T+33. X/M latch captures at the end of T+33.
- Divide by zero / div overflow: stall low at T; DONE and result_valid at T+1, exception=1.
- Back-to-back: a second mul/div reaching X at T+34 is accepted in IDLE at T+34. No bubble is required beyond the natural advance.
- start deasserting mid-operation (e.g. external flush) does not abort; only reset_n aborts.
- reset_n low during MUL at T+k: IDLE at T+k+1, stall=0, busy=0, result_valid never pulses for that operation.

## Test plan
- a=7, b=6, mul, start at T -> stall high T..T+32, result_valid at T+33, result=42, exception=0, rd_out=rd_in.
- a=-5, b=3 mul -> result=0xFFFFFFF1, exception=0; a=0x00010000, b=0x00010000 -> result=0, exception=1.
- a=100, b=-7 div -> result=0xFFFFFFF2 (-14), exception=0, at T+33; a=-100, b=7 -> 0xFFFFFFF2.
- a=5, b=0 div -> stall low at T, result_valid at T+1, result=0, exception=1. a=0x80000000, b=-1 -> result=0x80000000, exception=1 at T+1.
- mul start at T, reset_n=0 at T+10 -> IDLE at T+11, stall/busy/result_valid=0, and no pulse through T+40.
- Two consecutive muls (3*4 at T, 5*5 at T+34) -> results 12 at T+33 and 25 at T+67; stall low only at T+33.
